// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the sudoku run sequencer: status codes, FSM states,
// and the retry-seed LFSR step.
package sudoku_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WORKING = 2'b01,
    ST_SUCCESS = 2'b10,
    ST_FAIL    = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LAUNCH,
    S_RUN,
    S_RETRY,
    S_SUCCESS,
    S_FAIL
  } run_state_e;

  // Fibonacci step on the low w bits; an all-zero result is forced to 1 so the
  // retry sequence can never lock up.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s,
                                            input logic [31:0] taps,
                                            input int unsigned w);
    logic [31:0] mask;
    logic [31:0] r;
    mask = (32'd1 << w) - 32'd1;
    r    = ((s << 1) | 32'(^(s & taps & mask))) & mask;
    if (r == 32'd0) r = 32'd1;
    return r;
  endfunction

  function automatic status_e status_of(input run_state_e s);
    case (s)
      S_IDLE:    return ST_IDLE;
      S_SUCCESS: return ST_SUCCESS;
      S_FAIL:    return ST_FAIL;
      default:   return ST_WORKING;
    endcase
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchroniser for an asynchronous board input; presents either the
// synchronised level or a one-cycle rising-edge pulse.
module key_edge_sync #(
  parameter bit EDGE_ONLY = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic sync_out
);

  logic [2:0] sh;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sh <= '0;
    else          sh <= {sh[1:0], din};
  end

  assign sync_out = EDGE_ONLY ? (sh[1] & ~sh[2]) : sh[1];

endmodule

// File: rtl/sudoku_run_ctrl.sv
// Run sequencer for the grid solver: start/abort handling, clear-and-launch,
// watchdog, LFSR-reseeded retries and a registered status/attempt report.
module sudoku_run_ctrl
  import sudoku_pkg::*;
#(
  parameter int                SEED_W         = 8,
  parameter logic [SEED_W-1:0] LFSR_TAPS      = SEED_W'(8'hB8),
  parameter int                MAX_TRIES      = 4,
  parameter int                TIMEOUT_CYCLES = 1_000_000,
  parameter int                CLEAR_CYCLES   = 4
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [SEED_W-1:0]              seed_in,
  input  logic                           rq_start,
  input  logic                           rq_abort,
  input  logic                           grid_done,
  input  logic                           grid_success,
  output logic                           grid_reset,
  output logic                           grid_start,
  output logic [SEED_W-1:0]              grid_seed,
  output logic [1:0]                     status,
  output logic [$clog2(MAX_TRIES+1)-1:0] attempts
);

  localparam int AW = $clog2(MAX_TRIES + 1);
  localparam int WW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int CW = (CLEAR_CYCLES < 2) ? 1 : $clog2(CLEAR_CYCLES);

  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);
  localparam logic [AW-1:0] TRIES    = AW'(MAX_TRIES);

  logic start_edge;
  logic abort_lvl;

  key_edge_sync #(.EDGE_ONLY(1'b1)) u_start_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .din      (rq_start),
    .sync_out (start_edge)
  );

  key_edge_sync #(.EDGE_ONLY(1'b0)) u_abort_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .din      (rq_abort),
    .sync_out (abort_lvl)
  );

  run_state_e        state_q, state_d;
  status_e           status_q;
  logic [WW-1:0]     wdog_q, wdog_d;
  logic [CW-1:0]     clr_q, clr_d;
  logic [SEED_W-1:0] seed_d;
  logic [AW-1:0]     att_d;

  // NOTE: every signal assigned below gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    seed_d  = grid_seed;
    att_d   = attempts;
    wdog_d  = wdog_q;
    clr_d   = clr_q;

    // Abort outranks everything, including a start seen in the same cycle.
    if (abort_lvl) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_SUCCESS, S_FAIL: begin
          if (start_edge) begin
            state_d = S_CLEAR;
            seed_d  = seed_in;
            att_d   = '0;
            clr_d   = '0;
          end
        end
        S_CLEAR: begin
          if (clr_q == CLR_LAST) begin
            state_d = S_LAUNCH;
            att_d   = attempts + AW'(1);
            wdog_d  = '0;
          end else begin
            clr_d = clr_q + CW'(1);
          end
        end
        S_LAUNCH: state_d = S_RUN;
        S_RUN: begin
          // A done in the final watchdog cycle still reports its real result.
          if (grid_done && grid_success) begin
            state_d = S_SUCCESS;
          end else if (grid_done || wdog_q == WD_LAST) begin
            state_d = S_RETRY;
          end else if (wdog_q != '1) begin
            wdog_d = wdog_q + WW'(1);
          end
        end
        S_RETRY: begin
          if (attempts < TRIES) begin
            state_d = S_CLEAR;
            seed_d  = SEED_W'(lfsr_next(32'(grid_seed), 32'(LFSR_TAPS), SEED_W));
            clr_d   = '0;
          end else begin
            state_d = S_FAIL;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they change with the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      status_q   <= ST_IDLE;
      grid_reset <= 1'b1;
      grid_start <= 1'b0;
      grid_seed  <= '0;
      attempts   <= '0;
      wdog_q     <= '0;
      clr_q      <= '0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_of(state_d);
      grid_reset <= (state_d == S_IDLE) || (state_d == S_CLEAR);
      grid_start <= (state_d == S_LAUNCH);
      grid_seed  <= seed_d;
      attempts   <= att_d;
      wdog_q     <= wdog_d;
      clr_q      <= clr_d;
    end
  end

  assign status = status_q;

endmodule

// File: tb/tb_sudoku_run_ctrl.sv
// Scoreboard bench for sudoku_run_ctrl: a behavioural grid model answers each
// launch, and a monitor compares every launch and final result against a queue.
module tb_sudoku_run_ctrl;

  localparam int SEED_W    = 8;
  localparam int MAX_TRIES = 3;
  localparam int TIMEOUT   = 16;
  localparam int CLEAR     = 4;
  localparam int AW        = $clog2(MAX_TRIES + 1);

  logic              clock;
  logic              reset_n;
  logic [SEED_W-1:0] seed_in;
  logic              rq_start;
  logic              rq_abort;
  logic              grid_done;
  logic              grid_success;
  logic              grid_reset;
  logic              grid_start;
  logic [SEED_W-1:0] grid_seed;
  logic [1:0]        status;
  logic [AW-1:0]     attempts;

  sudoku_run_ctrl #(
    .SEED_W         (SEED_W),
    .LFSR_TAPS      (8'hB8),
    .MAX_TRIES      (MAX_TRIES),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CLEAR_CYCLES   (CLEAR)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .seed_in      (seed_in),
    .rq_start     (rq_start),
    .rq_abort     (rq_abort),
    .grid_done    (grid_done),
    .grid_success (grid_success),
    .grid_reset   (grid_reset),
    .grid_start   (grid_start),
    .grid_seed    (grid_seed),
    .status       (status),
    .attempts     (attempts)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Grid behaviour per attempt: 0 done+success, 1 done+fail, 2 never done.
  typedef struct {
    int kind;
    int dly;
  } plan_t;

  typedef struct {
    bit         is_launch;
    logic [7:0] seed;
    int         att;
    logic [1:0] st;
  } exp_t;

  plan_t stage[$];
  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    tests = 0;
  int    fails = 0;
  logic [1:0] fin_st;
  int         fin_att;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Seed advance from its definition: shift left, feed back tap parity, never 0.
  function automatic logic [7:0] ref_next(input logic [7:0] s);
    int n;
    n = (int'(s) * 2) % 256 + ($countones(s & 8'hB8) % 2);
    if (n == 0) n = 1;
    return 8'(n);
  endfunction

  // Expands one run from the attempt plan in 'stage' into expected events.
  task automatic model_run(input logic [7:0] seed);
    logic [7:0] s;
    bit         over;
    exp_t       e;
    s    = seed;
    over = 1'b0;
    for (int i = 0; i < MAX_TRIES && !over; i++) begin
      e = '{1'b1, s, i + 1, 2'b01};
      exp_q.push_back(e);
      plan_q.push_back(stage[i]);
      if (stage[i].kind == 0) begin
        e = '{1'b0, 8'h00, i + 1, 2'b10};
        exp_q.push_back(e);
        fin_st  = 2'b10;
        fin_att = i + 1;
        over    = 1'b1;
      end else if (i == MAX_TRIES - 1) begin
        e = '{1'b0, 8'h00, i + 1, 2'b11};
        exp_q.push_back(e);
        fin_st  = 2'b11;
        fin_att = i + 1;
      end else begin
        s = ref_next(s);
      end
    end
  endtask

  // Behavioural grid: answers each launch according to the queued plan.
  initial begin : grid_model
    plan_t p;
    grid_done    = 1'b0;
    grid_success = 1'b0;
    forever begin
      @(negedge clock);
      if (grid_start === 1'b1 && plan_q.size() > 0) begin
        p = plan_q.pop_front();
        if (p.kind != 2) begin
          repeat (p.dly) @(negedge clock);
          grid_done    = 1'b1;
          grid_success = (p.kind == 0);
          @(negedge clock);
          grid_done    = 1'b0;
          grid_success = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Monitor: every launch and every SUCCESS/FAIL entry must match the queue head.
  initial begin : monitor
    exp_t       e;
    logic [1:0] prev_st;
    int         rst_run;
    prev_st = 2'b00;
    rst_run = 0;
    forever begin
      @(negedge clock);
      if (grid_start === 1'b1) begin
        check("launch_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("launch_kind", 32'(e.is_launch), 32'd1);
          check("launch_seed", 32'(grid_seed), 32'(e.seed));
          check("launch_attempts", 32'(attempts), 32'(e.att));
          check("launch_status", 32'(status), 32'h1);
          check("launch_grid_reset_low", 32'(grid_reset), 32'd0);
          check("clear_before_launch", 32'(rst_run >= CLEAR), 32'd1);
        end
      end
      if (status !== prev_st && (status === 2'b10 || status === 2'b11)) begin
        check("result_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("result_kind", 32'(e.is_launch), 32'd0);
          check("result_status", 32'(status), 32'(e.st));
          check("result_attempts", 32'(attempts), 32'(e.att));
          check("result_grid_reset_low", 32'(grid_reset), 32'd0);
        end
      end
      rst_run = (grid_reset === 1'b1) ? rst_run + 1 : 0;
      prev_st = status;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press();
    rq_start = 1'b0;
    cycles(3);
    rq_start = 1'b1;
    cycles(4);
    rq_start = 1'b0;
  endtask

  task automatic wait_launch(input string name);
    int n;
    n = 0;
    while (grid_start !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(grid_start), 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    cycles(2);
    check({name, "_status"}, 32'(status), 32'(fin_st));
    check({name, "_attempts"}, 32'(attempts), 32'(fin_att));
  endtask

  task automatic set_stage(input int k0, input int d0, input int k1, input int d1,
                           input int k2, input int d2);
    stage.delete();
    stage.push_back('{k0, d0});
    stage.push_back('{k1, d1});
    stage.push_back('{k2, d2});
  endtask

  initial begin : timeout_guard
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    exp_t       e;
    int         lat;
    logic [7:0] s;
    reset_n  = 1'b0;
    rq_start = 1'b0;
    rq_abort = 1'b0;
    seed_in  = '0;
    cycles(2);
    check("rst_grid_reset", 32'(grid_reset), 32'd1);
    check("rst_grid_start", 32'(grid_start), 32'd0);
    check("rst_grid_seed", 32'(grid_seed), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_attempts", 32'(attempts), 32'd0);
    reset_n = 1'b1;
    cycles(3);

    // 1: single successful attempt, with start-to-launch latency.
    seed_in = 8'h2A;
    set_stage(0, 10, 2, 0, 2, 0);
    model_run(8'h2A);
    rq_start = 1'b1;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (grid_start !== 1'b1 && lat < 50);
    check("start_latency", 32'(lat), 32'(CLEAR + 3));
    rq_start = 1'b0;
    wait_drain("t1_success");

    // 2: three timeouts -> FAIL, seeds 01,02,04.
    seed_in = 8'h01;
    set_stage(2, 0, 2, 0, 2, 0);
    model_run(8'h01);
    press();
    wait_drain("t2_timeouts");

    // 3: fail then succeed -> seeds 2A,54.
    seed_in = 8'h2A;
    set_stage(1, 5, 0, 7, 2, 0);
    model_run(8'h2A);
    press();
    wait_drain("t3_retry_success");

    // 4: zero seed and MSB-only seed must both advance to 01.
    seed_in = 8'h00;
    set_stage(1, 3, 0, 4, 2, 0);
    model_run(8'h00);
    press();
    wait_drain("t4_seed_zero");
    seed_in = 8'h80;
    set_stage(1, 16, 0, 1, 2, 0);
    model_run(8'h80);
    press();
    wait_drain("t4_seed_80");

    // 5: abort during RUN, then start pressed while abort held, then a clean rerun.
    seed_in = 8'h5C;
    e = '{1'b1, 8'h5C, 1, 2'b01};
    exp_q.push_back(e);
    plan_q.push_back('{2, 0});
    rq_start = 1'b0;
    cycles(3);
    rq_start = 1'b1;
    wait_launch("t5_launch_seen");
    cycles(3);
    rq_abort = 1'b1;
    rq_start = 1'b0;
    cycles(3);
    check("abort_status", 32'(status), 32'd0);
    check("abort_grid_reset", 32'(grid_reset), 32'd1);
    check("abort_attempts_kept", 32'(attempts), 32'd1);
    rq_start = 1'b1;
    cycles(5);
    rq_abort = 1'b0;
    cycles(8);
    check("abort_drops_start", 32'(status), 32'd0);
    seed_in = 8'h33;
    set_stage(1, 2, 1, 9, 0, 3);
    model_run(8'h33);
    press();
    wait_drain("t5_rerun");

    // 6: done+success on the final watchdog cycle, with start activity during RUN.
    seed_in = 8'hC3;
    set_stage(0, TIMEOUT, 2, 0, 2, 0);
    model_run(8'hC3);
    rq_start = 1'b0;
    cycles(3);
    rq_start = 1'b1;
    wait_launch("t6_launch_seen");
    cycles(2);
    rq_start = 1'b0;
    cycles(2);
    rq_start = 1'b1;
    cycles(2);
    rq_start = 1'b0;
    cycles(2);
    rq_start = 1'b1;
    wait_drain("t6_coincident");
    cycles(10);
    check("t6_held_start_no_rerun", 32'(status), 32'h2);
    rq_start = 1'b0;

    // 6b: asynchronous reset in the middle of RUN.
    seed_in = 8'h77;
    e = '{1'b1, 8'h77, 1, 2'b01};
    exp_q.push_back(e);
    plan_q.push_back('{2, 0});
    press();
    wait_launch("t6b_launch_seen");
    cycles(3);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_grid_reset", 32'(grid_reset), 32'd1);
    check("async_rst_grid_start", 32'(grid_start), 32'd0);
    check("async_rst_grid_seed", 32'(grid_seed), 32'd0);
    check("async_rst_status", 32'(status), 32'd0);
    check("async_rst_attempts", 32'(attempts), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    cycles(3);

    // Randomised runs against the model.
    for (int r = 0; r < 10; r++) begin
      s = 8'($urandom);
      seed_in = s;
      stage.delete();
      for (int i = 0; i < MAX_TRIES; i++)
        stage.push_back('{int'($urandom_range(0, 2)), int'($urandom_range(1, TIMEOUT))});
      model_run(s);
      press();
      wait_drain("rand_run");
    end

    cycles(5);
    check("plan_consumed", 32'(plan_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
